// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - command encodings, mode-register fields and helpers for the SDRAM responder
package sdram_pkg;

    // {nCS, nRAS, nCAS, nWE}
    localparam logic [3:0] ENC_LOAD_MODE  = 4'b0000;
    localparam logic [3:0] ENC_REFRESH    = 4'b0001;
    localparam logic [3:0] ENC_PRECHARGE  = 4'b0010;
    localparam logic [3:0] ENC_ACTIVE     = 4'b0011;
    localparam logic [3:0] ENC_WRITE      = 4'b0100;
    localparam logic [3:0] ENC_READ       = 4'b0101;
    localparam logic [3:0] ENC_BURST_TERM = 4'b0110;
    localparam logic [3:0] ENC_NOP        = 4'b0111;

    typedef enum logic [3:0] {
        CMD_LOAD_MODE  = ENC_LOAD_MODE,
        CMD_REFRESH    = ENC_REFRESH,
        CMD_PRECHARGE  = ENC_PRECHARGE,
        CMD_ACTIVE     = ENC_ACTIVE,
        CMD_WRITE      = ENC_WRITE,
        CMD_READ       = ENC_READ,
        CMD_BURST_TERM = ENC_BURST_TERM,
        CMD_NOP        = ENC_NOP
    } cmd_e;

    // Mode-register field positions
    localparam int MR_BL_LSB = 0;
    localparam int MR_BL_MSB = 2;
    localparam int MR_BT_BIT = 3;
    localparam int MR_CL_LSB = 4;
    localparam int MR_CL_MSB = 6;
    localparam int MR_WB_BIT = 9;

    // Only CL 2 and 3 exist on the part; anything else behaves as 3.
    function automatic logic [1:0] cl_eff(input logic [12:0] mode);
        return (mode[MR_CL_MSB:MR_CL_LSB] == 3'd2) ? 2'd2 : 2'd3;
    endfunction

    // A mode value we can honour: CL 2/3 and single-word bursts.
    function automatic logic mode_legal(input logic [12:0] mode);
        return ((mode[MR_CL_MSB:MR_CL_LSB] == 3'd2) || (mode[MR_CL_MSB:MR_CL_LSB] == 3'd3))
               && (mode[MR_BL_MSB:MR_BL_LSB] == 3'd0);
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// rtl/sdram_responder_if.sv - SDRAM command/address bus seen by the responder
interface sdram_responder_if;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic        SDRAM_CKE;

    modport master (
        output SDRAM_A, SDRAM_BA, SDRAM_DQML, SDRAM_DQMH,
        output SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE
    );

    modport slave (
        input SDRAM_A, SDRAM_BA, SDRAM_DQML, SDRAM_DQMH,
        input SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, SDRAM_CKE
    );
endinterface

// File: rtl/sdram_resp_bank.sv
// rtl/sdram_resp_bank.sv - per-bank open/row state and ACTIVE-to-access timer (SDRAM_RESP_TIMING_CHECK_EN)
module sdram_resp_bank #(
    parameter int T_RCD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_activate,
    input  logic        i_precharge,
    input  logic        i_access,      // READ/WRITE with auto-precharge on this bank
    input  logic [12:0] i_row,
    output logic        o_is_open,
    output logic [12:0] o_row,
    output logic        o_rcd_ok
);

    logic        r_open;
    logic [12:0] r_row;

    // Open on ACTIVE, close on PRECHARGE or an auto-precharging access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open <= 1'b0;
            r_row  <= 13'd0;
        end else if (i_activate) begin
            r_open <= 1'b1;
            r_row  <= i_row;
        end else if (i_precharge || i_access) begin
            r_open <= 1'b0;
        end
    end

    assign o_is_open = r_open;
    assign o_row     = r_row;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    localparam int RCD_W = $clog2(T_RCD + 2);

    // Cycles since ACTIVE; value d at an edge means the ACTIVE was d edges ago
    logic [RCD_W-1:0] r_rcd_cnt;

    // Restart on ACTIVE, count up and saturate at T_RCD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcd_cnt <= RCD_W'(T_RCD);
        end else if (i_activate) begin
            r_rcd_cnt <= RCD_W'(1);
        end else if (r_rcd_cnt < RCD_W'(T_RCD)) begin
            r_rcd_cnt <= r_rcd_cnt + RCD_W'(1);
        end
    end

    assign o_rcd_ok = (r_rcd_cnt >= RCD_W'(T_RCD));
`else
    logic [31:0] w_unused_rcd;
    assign w_unused_rcd = 32'(T_RCD);
    assign o_rcd_ok     = 1'b1;
`endif

endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - device-side SDRAM model with protocol checks; timing checks under SDRAM_RESP_TIMING_CHECK_EN
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_BITS    = 4,
    parameter int T_RCD       = 2,
    parameter int T_RP        = 2,
    parameter int T_RFC       = 6,
    parameter int T_MRD       = 2,
    parameter int REFRESH_MAX = 1600
) (
    input  logic              clk_sdram,
    input  logic              init_n,
    sdram_responder_if.slave  bus,
    inout  wire  [15:0]       SDRAM_DQ,
    output logic [12:0]       mode_reg,
    output logic              mode_loaded,
    output logic [15:0]       refresh_cnt,
    output logic              err_protocol,
    output logic              err_timing
);

    localparam int MEM_AW = ROW_BITS + 10;

    logic [15:0] r_mem [0:(2**MEM_AW)-1];

    logic [12:0] w_a;
    logic [1:0]  w_ba;
    logic [1:0]  w_dqm;
    logic [15:0] w_dq_in;
    cmd_e        w_cmd;

    assign w_a     = bus.SDRAM_A;
    assign w_ba    = bus.SDRAM_BA;
    assign w_dqm   = {bus.SDRAM_DQMH, bus.SDRAM_DQML};
    assign w_dq_in = SDRAM_DQ;

    // Command decode; deselected or clock-disabled cycles are NOP
    always_comb begin
        w_cmd = CMD_NOP;
        if (bus.SDRAM_CKE && !bus.SDRAM_nCS) begin
            w_cmd = cmd_e'({bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE});
        end
    end

    logic w_is_lm, w_is_ref, w_is_pre, w_is_act, w_is_wr, w_is_rd, w_non_nop;
    assign w_is_lm   = (w_cmd == CMD_LOAD_MODE);
    assign w_is_ref  = (w_cmd == CMD_REFRESH);
    assign w_is_pre  = (w_cmd == CMD_PRECHARGE);
    assign w_is_act  = (w_cmd == CMD_ACTIVE);
    assign w_is_wr   = (w_cmd == CMD_WRITE);
    assign w_is_rd   = (w_cmd == CMD_READ);
    assign w_non_nop = (w_cmd != CMD_NOP);

    logic [3:0]  w_bank_open;
    logic [3:0]  w_rcd_ok;
    logic [12:0] w_row [4];
    logic [3:0]  w_act_b, w_pre_b, w_acc_b;

    // Per-bank strobes: A10 selects all banks on PRECHARGE and auto-precharge on READ/WRITE
    always_comb begin
        w_act_b = 4'd0;
        w_pre_b = 4'd0;
        w_acc_b = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_act_b[i] = w_is_act && (w_ba == 2'(i));
            w_pre_b[i] = w_is_pre && (w_a[10] || (w_ba == 2'(i)));
            w_acc_b[i] = (w_is_rd || w_is_wr) && w_a[10] && (w_ba == 2'(i));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        sdram_resp_bank #(.T_RCD(T_RCD)) u_bank (
            .clk         (clk_sdram),
            .rst_n       (init_n),
            .i_activate  (w_act_b[g]),
            .i_precharge (w_pre_b[g]),
            .i_access    (w_acc_b[g]),
            .i_row       (w_a),
            .o_is_open   (w_bank_open[g]),
            .o_row       (w_row[g]),
            .o_rcd_ok    (w_rcd_ok[g])
        );
    end

    logic              w_sel_open;
    logic              w_any_open;
    logic [12:0]       w_row_sel;
    logic [MEM_AW-1:0] w_idx;
    logic [1:0]        w_cl;

    assign w_sel_open = w_bank_open[w_ba];
    assign w_any_open = |w_bank_open;
    assign w_row_sel  = w_row[w_ba];
    assign w_idx      = {w_ba, w_row_sel[ROW_BITS-1:0], w_a[7:0]};

    logic [12:0] r_mode_reg;
    logic        r_mode_loaded;
    logic [15:0] r_refresh_cnt;
    logic        r_err_protocol;
    logic [1:0]  r_dq_oe;
    logic [15:0] r_dq_out;

    assign w_cl = cl_eff(r_mode_reg);

    logic w_proto_err;
    assign w_proto_err = (w_is_lm  && (w_any_open || !mode_legal(w_a)))
                       | (w_is_act && (w_sel_open || !r_mode_loaded))
                       | ((w_is_rd || w_is_wr) && !w_sel_open)
                       | (w_is_ref && w_any_open)
                       | (w_is_wr  && (|r_dq_oe));

    // Byte-masked write into the array; contents survive reset
    always_ff @(posedge clk_sdram) begin
        if (w_is_wr && w_sel_open) begin
            if (!w_dqm[0]) r_mem[w_idx][7:0]  <= w_dq_in[7:0];
            if (!w_dqm[1]) r_mem[w_idx][15:8] <= w_dq_in[15:8];
        end
    end

    // Mode register, refresh count and sticky protocol flag
    always_ff @(posedge clk_sdram or negedge init_n) begin
        if (!init_n) begin
            r_mode_reg     <= 13'd0;
            r_mode_loaded  <= 1'b0;
            r_refresh_cnt  <= 16'd0;
            r_err_protocol <= 1'b0;
        end else begin
            if (w_is_lm) begin
                r_mode_reg    <= w_a;
                r_mode_loaded <= 1'b1;
            end
            if (w_is_ref) r_refresh_cnt <= r_refresh_cnt + 16'd1;
            if (w_proto_err) r_err_protocol <= 1'b1;
        end
    end

    logic        r_p1_vld, r_p2_vld, r_p3_vld;
    logic [15:0] r_p1_data, r_p2_data, r_p3_data;
    logic [1:0]  r_p3_mask;

    // Read pipeline: stage n holds a READ issued n edges ago; DQM is captured at stage 2
    always_ff @(posedge clk_sdram or negedge init_n) begin
        if (!init_n) begin
            r_p1_vld  <= 1'b0;
            r_p2_vld  <= 1'b0;
            r_p3_vld  <= 1'b0;
            r_p1_data <= 16'd0;
            r_p2_data <= 16'd0;
            r_p3_data <= 16'd0;
            r_p3_mask <= 2'b00;
            r_dq_oe   <= 2'b00;
            r_dq_out  <= 16'd0;
        end else begin
            r_p1_vld  <= w_is_rd && w_sel_open;
            r_p1_data <= r_mem[w_idx];
            r_p2_vld  <= r_p1_vld;
            r_p2_data <= r_p1_data;
            r_p3_vld  <= r_p2_vld && (w_cl == 2'd3);
            r_p3_data <= r_p2_data;
            r_p3_mask <= w_dqm;
            r_dq_oe   <= 2'b00;
            if ((w_cl == 2'd2) && r_p2_vld) begin
                r_dq_out <= r_p2_data;
                r_dq_oe  <= ~w_dqm;
            end else if (r_p3_vld) begin
                r_dq_out <= r_p3_data;
                r_dq_oe  <= ~r_p3_mask;
            end
        end
    end

    assign SDRAM_DQ[7:0]  = r_dq_oe[0] ? r_dq_out[7:0]  : 8'hzz;
    assign SDRAM_DQ[15:8] = r_dq_oe[1] ? r_dq_out[15:8] : 8'hzz;

    assign mode_reg     = r_mode_reg;
    assign mode_loaded  = r_mode_loaded;
    assign refresh_cnt  = r_refresh_cnt;
    assign err_protocol = r_err_protocol;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    localparam int RP_W  = $clog2(T_RP + 2);
    localparam int RFC_W = $clog2(T_RFC + 2);
    localparam int MRD_W = $clog2(T_MRD + 2);
    localparam int WD_W  = $clog2(REFRESH_MAX + 3);

    logic [RP_W-1:0]  r_rp_cnt;
    logic [RFC_W-1:0] r_rfc_cnt;
    logic [MRD_W-1:0] r_mrd_cnt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic             r_err_timing;

    // Global timers: restart at 1 on their command, saturate at the limit
    always_ff @(posedge clk_sdram or negedge init_n) begin
        if (!init_n) begin
            r_rp_cnt  <= RP_W'(T_RP);
            r_rfc_cnt <= RFC_W'(T_RFC);
            r_mrd_cnt <= MRD_W'(T_MRD);
            r_wd_cnt  <= WD_W'(REFRESH_MAX + 1);
        end else begin
            if (w_is_pre)                            r_rp_cnt <= RP_W'(1);
            else if (r_rp_cnt < RP_W'(T_RP))         r_rp_cnt <= r_rp_cnt + RP_W'(1);
            if (w_is_ref)                            r_rfc_cnt <= RFC_W'(1);
            else if (r_rfc_cnt < RFC_W'(T_RFC))      r_rfc_cnt <= r_rfc_cnt + RFC_W'(1);
            if (w_is_lm)                             r_mrd_cnt <= MRD_W'(1);
            else if (r_mrd_cnt < MRD_W'(T_MRD))      r_mrd_cnt <= r_mrd_cnt + MRD_W'(1);
            if (w_is_ref || (w_is_lm && !r_mode_loaded)) r_wd_cnt <= WD_W'(1);
            else if (r_wd_cnt < WD_W'(REFRESH_MAX + 1))  r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    logic w_timing_err;
    assign w_timing_err = ((w_is_act || w_is_ref) && (r_rp_cnt < RP_W'(T_RP)))
                        | ((w_is_rd || w_is_wr) && !w_rcd_ok[w_ba])
                        | (w_non_nop && (r_rfc_cnt < RFC_W'(T_RFC)))
                        | (w_non_nop && (r_mrd_cnt < MRD_W'(T_MRD)))
                        | (r_mode_loaded && (r_wd_cnt > WD_W'(REFRESH_MAX)));

    // Sticky timing flag
    always_ff @(posedge clk_sdram or negedge init_n) begin
        if (!init_n) r_err_timing <= 1'b0;
        else if (w_timing_err) r_err_timing <= 1'b1;
    end

    assign err_timing = r_err_timing;
`else
    logic w_unused_timing;
    assign w_unused_timing = ^{w_rcd_ok, w_non_nop, 32'(T_RP), 32'(T_RFC), 32'(T_MRD), 32'(REFRESH_MAX)};
    assign err_timing = 1'b0;
`endif

    logic w_unused_bits;
    assign w_unused_bits = ^{w_row_sel[12:ROW_BITS]};

endmodule
